// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer.
// Opcodes, FSM states, iteration limit and a magnitude helper.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [4:0] ITER_MAX = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_RESP
  } alu_state_t;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between control unit and ALU sequencer.
// The control unit is the master; the sequencer is the slave.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [4:0]         opcode;
  logic [WIDTH-1:0]   Ra;
  logic [WIDTH-1:0]   Rb;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] Rc;
  logic               hilo_we;
  logic               div_by_zero;
  logic               illegal_op;
  logic               busy;

  modport master (
    output req_valid, opcode, Ra, Rb, rsp_ready,
    input  req_ready, rsp_valid, Rc, hilo_we,
    input  div_by_zero, illegal_op, busy
  );

  modport slave (
    input  req_valid, opcode, Ra, Rb, rsp_ready,
    output req_ready, rsp_valid, Rc, hilo_we,
    output div_by_zero, illegal_op, busy
  );
endinterface

// File: rtl/muldiv_core.sv
// Unsigned iterative multiply (shift-add) / divide (restoring).
// hi/lo present the accumulator/shift pair after the current step.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] hi_step;
  logic [WIDTH-1:0] lo_step;

  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, b_q};
    rem  = {acc_q, sh_q[WIDTH-1]};
    diff = rem - {1'b0, b_q};
    hi_step = acc_q;
    lo_step = sh_q;
    if (div_q) begin
      // diff MSB set means the trial subtract borrowed
      if (diff[WIDTH]) begin
        hi_step = rem[WIDTH-1:0];
        lo_step = {sh_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_step = diff[WIDTH-1:0];
        lo_step = {sh_q[WIDTH-2:0], 1'b1};
      end
    end else if (sh_q[0]) begin
      {hi_step, lo_step} = {sum, sh_q[WIDTH-1:1]};
    end else begin
      {hi_step, lo_step} = {1'b0, acc_q, sh_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (start) begin
      acc_d = '0;
      sh_d  = a_mag;
      b_d   = b_mag;
      cnt_d = ITER_MAX;
      div_d = is_div;
    end else if (step) begin
      acc_d = hi_step;
      sh_d  = lo_step;
      cnt_d = last ? 5'd0 : cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign last = (cnt_q == 5'd0);
  assign hi   = hi_step;
  assign lo   = lo_step;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU sequencer: handshake FSM, single-cycle ops, sign handling
// around the iterative mul/div core, and response registers.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  alu_op_sequencer_if.slave bus
);

  alu_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] rc_q, rc_d;
  logic               hilo_q, hilo_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;
  logic               neg_q, neg_d;
  logic               ran_q, ran_d;

  logic               req_ready;
  logic               accept;
  logic               start;
  logic               step;
  logic               is_div;
  logic               core_last;
  logic [WIDTH-1:0]   core_hi;
  logic [WIDTH-1:0]   core_lo;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_legal;
  logic [5:0]         sh;
  logic [5:0]         sh_inv;
  logic [2*WIDTH-1:0] mul_p;
  logic [2*WIDTH-1:0] mul_fix;
  logic [2*WIDTH-1:0] div_fix;

  assign req_ready = !reset &&
    ((state_q == S_IDLE) ||
     (state_q == S_RESP && bus.rsp_ready));
  assign accept = bus.req_valid && req_ready;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .is_div (is_div),
    .a_mag  (mag(bus.Ra)),
    .b_mag  (mag(bus.Rb)),
    .step   (step),
    .last   (core_last),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  always_comb begin
    sh       = {1'b0, bus.Rb[4:0]};
    sh_inv   = 6'd32 - sh;
    sc_res   = '0;
    sc_legal = 1'b1;
    case (bus.opcode)
      OP_ADD:  sc_res = bus.Ra + bus.Rb;
      OP_SUB:  sc_res = bus.Ra - bus.Rb;
      OP_AND:  sc_res = bus.Ra & bus.Rb;
      OP_OR:   sc_res = bus.Ra | bus.Rb;
      OP_SHR:  sc_res = bus.Ra >> sh;
      OP_SHRA: sc_res = $signed(bus.Ra) >>> sh;
      OP_SHL:  sc_res = bus.Ra << sh;
      OP_ROR:  sc_res = (bus.Ra >> sh) | (bus.Ra << sh_inv);
      OP_ROL:  sc_res = (bus.Ra << sh) | (bus.Ra >> sh_inv);
      OP_NEG:  sc_res = ~bus.Ra + 1'b1;
      OP_NOT:  sc_res = ~bus.Ra;
      default: sc_legal = 1'b0;
    endcase
  end

  always_comb begin
    mul_p   = {core_hi, core_lo};
    mul_fix = neg_q ? (~mul_p + 1'b1) : mul_p;
    div_fix = {ran_q ? (~core_hi + 1'b1) : core_hi,
               neg_q ? (~core_lo + 1'b1) : core_lo};
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    hilo_d  = hilo_q;
    dbz_d   = dbz_q;
    ill_d   = ill_q;
    neg_d   = neg_q;
    ran_d   = ran_q;
    start   = 1'b0;
    step    = 1'b0;
    is_div  = (bus.opcode == OP_DIV);
    case (state_q)
      S_IDLE, S_RESP: begin
        if (state_q == S_RESP && bus.rsp_ready)
          state_d = S_IDLE;
        if (accept) begin
          neg_d = bus.Ra[WIDTH-1] ^ bus.Rb[WIDTH-1];
          ran_d = bus.Ra[WIDTH-1];
          if (bus.opcode == OP_MUL ||
              (is_div && bus.Rb != '0)) begin
            start   = 1'b1;
            state_d = is_div ? S_DIV : S_MUL;
          end else begin
            state_d = S_RESP;
            hilo_d  = 1'b0;
            dbz_d   = 1'b0;
            ill_d   = 1'b0;
            if (is_div) begin
              rc_d   = {bus.Ra, {WIDTH{1'b1}}};
              hilo_d = 1'b1;
              dbz_d  = 1'b1;
            end else if (sc_legal) begin
              rc_d = {{WIDTH{1'b0}}, sc_res};
            end else begin
              rc_d  = '0;
              ill_d = 1'b1;
            end
          end
        end
      end
      S_MUL, S_DIV: begin
        step = 1'b1;
        if (core_last) begin
          state_d = S_RESP;
          rc_d    = (state_q == S_DIV) ? div_fix : mul_fix;
          hilo_d  = 1'b1;
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      hilo_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
      neg_q   <= 1'b0;
      ran_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      hilo_q  <= hilo_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
      neg_q   <= neg_d;
      ran_q   <= ran_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.Rc          = rc_q;
  assign bus.hilo_we     = hilo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;
  assign bus.busy        = (state_q == S_MUL) || (state_q == S_DIV);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: driver pushes expected
// responses, a negedge monitor pops and compares them.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [63:0] rc;
    logic        hw;
    logic        dz;
    logic        il;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_op_sequencer_if #(.WIDTH(32)) bus();

  alu_op_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int prev_rsp_cyc = 0;
  int busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.rsp_valid && bus.rsp_ready) begin
      prev_rsp_cyc = rsp_cyc;
      rsp_cyc = cyc;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got Rc=%h, no response expected",
                 bus.Rc);
      end else begin
        mon_e = sbq.pop_front();
        if (bus.Rc !== mon_e.rc || bus.hilo_we !== mon_e.hw ||
            bus.div_by_zero !== mon_e.dz ||
            bus.illegal_op !== mon_e.il) begin
          fails++;
          $display("FAIL %s: got Rc=%h hw=%b dz=%b il=%b, want Rc=%h hw=%b dz=%b il=%b",
                   mon_e.nm, bus.Rc, bus.hilo_we, bus.div_by_zero,
                   bus.illegal_op, mon_e.rc, mon_e.hw, mon_e.dz, mon_e.il);
        end
      end
    end
  end

  function automatic exp_t mk(input logic [63:0] rc, input logic hw,
                              input logic dz, input logic il,
                              input string nm);
    exp_t e;
    e.rc = rc; e.hw = hw; e.dz = dz; e.il = il; e.nm = nm;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e,
                      input bit push);
    int n;
    bus.req_valid = 1'b1;
    bus.opcode = op;
    bus.Ra = a;
    bus.Rb = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL %s_accept: req_ready stuck low, want 1", e.nm);
        bus.req_valid = 1'b0;
        return;
      end
    end
    if (push) sbq.push_back(e);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sbq.size() == 0 && !bus.rsp_valid && !bus.busy) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL drain: %0d responses pending, want 0", sbq.size());
        sbq.delete();
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic op1(input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] rc,
                     input logic hw, input logic dz, input logic il,
                     input string nm);
    send(op, a, b, mk(rc, hw, dz, il, nm), 1'b1);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.opcode = '0;
    bus.Ra = '0;
    bus.Rb = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rc", bus.Rc, 64'd0);
    chk("rst_flags", {61'd0, bus.hilo_we, bus.div_by_zero,
        bus.illegal_op}, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;

    send(OP_ADD, 32'h7FFFFFFF, 32'd1,
         mk(64'h0000000080000000, 0, 0, 0, "add_wrap"), 1'b1);
    wait_idle();
    chk("add_latency", 64'(rsp_cyc - acc_cyc), 64'd1);

    send(OP_AND, 32'h0F0F0F0F, 32'hFFFF00F0,
         mk(64'h000000000F0F0000, 0, 0, 0, "and_b2b"), 1'b1);
    send(OP_OR, 32'h0F0F0F0F, 32'h000000F0,
         mk(64'h000000000F0F0FFF, 0, 0, 0, "or_b2b"), 1'b1);
    wait_idle();
    chk("b2b_gap", 64'(rsp_cyc - prev_rsp_cyc), 64'd1);

    busy_cnt = 0;
    send(OP_MUL, 32'hFFFFFFFA, 32'd7,
         mk(64'hFFFFFFFFFFFFFFD6, 1, 0, 0, "mul_neg"), 1'b1);
    wait_idle();
    chk("mul_latency", 64'(rsp_cyc - acc_cyc), 64'd33);
    chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);

    op1(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD,
        1, 0, 0, "div_m7_2");
    op1(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000,
        1, 0, 0, "div_min_m1");
    op1(OP_DIV, 32'd100, 32'd7, 64'h00000002_0000000E,
        1, 0, 0, "div_100_7");
    op1(OP_DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD,
        1, 0, 0, "div_7_m2");
    send(OP_DIV, 32'd5, 32'd0,
         mk(64'h00000005_FFFFFFFF, 1, 1, 0, "div_zero"), 1'b1);
    wait_idle();
    chk("divz_latency", 64'(rsp_cyc - acc_cyc), 64'd1);
    op1(OP_MUL, 32'h80000000, 32'h80000000, 64'h4000000000000000,
        1, 0, 0, "mul_min_min");

    op1(OP_SHRA, 32'h80000000, 32'h24, 64'hF8000000, 0, 0, 0, "shra4");
    op1(OP_ROL, 32'h80000001, 32'd1, 64'h00000003, 0, 0, 0, "rol1");
    op1(5'b11111, 32'h1234, 32'h5678, 64'd0, 0, 0, 1, "illegal");
    op1(OP_SUB, 32'd0, 32'd1, 64'hFFFFFFFF, 0, 0, 0, "sub_wrap");
    op1(OP_NEG, 32'd5, 32'd0, 64'hFFFFFFFB, 0, 0, 0, "neg5");
    op1(OP_NOT, 32'h0000FFFF, 32'd0, 64'hFFFF0000, 0, 0, 0, "not");
    op1(OP_SHR, 32'h80000000, 32'd31, 64'h1, 0, 0, 0, "shr31");
    op1(OP_SHL, 32'd1, 32'd31, 64'h80000000, 0, 0, 0, "shl31");
    op1(OP_ROR, 32'd1, 32'd1, 64'h80000000, 0, 0, 0, "ror1");
    op1(OP_ROR, 32'h12345678, 32'hFFFFFFE0, 64'h12345678,
        0, 0, 0, "ror0");

    bus.rsp_ready = 1'b0;
    send(OP_MUL, 32'd3, 32'd5, mk(64'd15, 1, 0, 0, "mul_bp"), 1'b1);
    bus.opcode = OP_ADD;
    bus.Ra = 32'hDEADBEEF;
    bus.Rb = 32'h0BADF00D;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 100);
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rc_stable", bus.Rc, 64'd15);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    send(OP_ADD, 32'd2, 32'd3, mk(64'd5, 0, 0, 0, "add_after_bp"), 1'b1);
    chk("bp_same_edge", 64'(rsp_cyc), 64'(acc_cyc));
    wait_idle();

    send(OP_DIV, 32'd100, 32'd7, mk(64'd0, 0, 0, 0, "div_abort"), 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_pre", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_rc", bus.Rc, 64'd0);
    chk("abort_flags", {61'd0, bus.hilo_we, bus.div_by_zero,
        bus.illegal_op}, 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (40) @(posedge clk);
    #1;
    op1(OP_ADD, 32'd10, 32'd20, 64'd30, 0, 0, 0, "add_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
